writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
Single-write-port arbiter sitting directly upstream of the decode-stage register file; it drives that file's write-enable/address/data port (write port 3). It merges two result sources: the in-order pipeline writeback (fixed priority, never stalled) and a long-latency unit (multiply/divide, miss-return loads) that delivers via valid/ready into a small FIFO. It kills stale buffered results overwritten by younger pipeline writes, and exports a pending-destination mask for the hazard unit.

Parameters:
DATA_WIDTH, 64, register data width
ADDR_WIDTH, 5, register index width
REG_DEPTH, 32, number of architectural registers (width of pending mask)
FIFO_DEPTH, 4, long-latency result buffer entries; power of 2, >= 2

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rstn  input  1  synchronous active-low reset
i_wb_valid  input  1  pipeline writeback valid
i_wb_rd  input  ADDR_WIDTH  pipeline destination register
i_wb_data  input  DATA_WIDTH  pipeline result
i_lu_valid  input  1  long-latency result valid
i_lu_rd  input  ADDR_WIDTH  long-latency destination register
i_lu_data  input  DATA_WIDTH  long-latency result
o_lu_ready  output  1  FIFO can accept a long-latency result this cycle
o_write_en_3  output  1  register file write enable
o_addr_3  output  ADDR_WIDTH  register file write address
o_write_data_3  output  DATA_WIDTH  register file write data
o_pending_mask  output  REG_DEPTH  bit r set: a live buffered result targets register r
o_empty  output  1  FIFO holds no entries

Behaviour:
- Clock i_clk; reset i_rstn is synchronous, active-low, sampled on rising edge only.
- Reset: FIFO pointers/count cleared, all entry valid/kill flags cleared; buffered contents discarded (also if asserted mid-operation). While i_rstn=0: o_lu_ready=0, o_write_en_3=0, o_addr_3=0, o_write_data_3=0, o_pending_mask=0, o_empty=1.
- Handshake: push when i_lu_valid & o_lu_ready. o_lu_ready = !full, full computed from registered count only (no same-cycle pop bypass). Producer holds valid/rd/data stable until accepted.
- i_lu_rd==0: handshake completes, entry not pushed (discarded).
- Write port, combinational, priority order:
  1. i_wb_valid & i_wb_rd!=0 -> write i_wb_rd/i_wb_data same cycle (0 latency). No FIFO pop.
  2. Else, FIFO non-empty, head live -> write head rd/data; pop head.
  3. Else, FIFO non-empty, head killed -> pop head, o_write_en_3=0.
  4. Else o_write_en_3=0, o_addr_3=0, o_write_data_3=0.
- i_wb_valid with i_wb_rd==0: treated as no pipeline write; FIFO may drain that cycle.
- Long-latency latency: accepted in cycle N, earliest register write in cycle N+1.
- At most one pop per cycle; push and pop may occur in the same cycle.
- Ordering: buffered results always belong to instructions older than the current pipeline writeback (guaranteed by issue logic).
- Kill rule: on a pipeline write to rd X (X!=0), every FIFO entry with rd X gets its kill flag set at that edge, and a same-cycle incoming push with rd X is stored already killed.
- o_pending_mask: registered. OR of onehot(rd) over entries that are valid and not killed, reflecting post-edge state. o_empty = (count==0).
- Count width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package: typedef wb_req_t {rd, data}; constants REG_ZERO=0 and FIFO_DEPTH default.
- One sub-module: wb_result_fifo. Circular buffer with per-entry valid/kill flags, kill-by-rd match input, and pending-mask generation.
- The arbiter mux stays in the top module.

Test Plan:
- Reset: drive i_rstn=0 with i_lu_valid=1 for 2 cycles, release -> no push. Cycle after release: o_lu_ready=1, o_empty=1, o_pending_mask=0.
- Pipeline only: wb_valid=1, rd=5, data=0xAA -> same cycle o_write_en_3=1, o_addr_3=5, o_write_data_3=0xAA.
- Long-latency drain: push rd=7, data=0x1234 at cycle N with wb idle -> o_pending_mask[7]=1 after edge N. At N+1: write rd 7 with 0x1234. After that edge: mask=0, o_empty=1.
- Full/backpressure: 4 pushes while wb_valid=1 every cycle (rd=1) -> o_lu_ready=0 on 5th cycle. Drop wb_valid -> 4 writes in FIFO order on consecutive cycles. o_lu_ready returns 1 the cycle after the first pop.
- Kill: buffer rd=9 (0x11), then wb write rd=9 (0x22) -> mask[9] clears. Head later pops with no write. Register 9 keeps 0x22.
- Simultaneous push and wb write to the same rd=3 -> entry stored killed and never written. Push with rd=0 -> accepted, o_empty stays 1.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared types and constants for the writeback arbiter
package writeback_arbiter_pkg;

  localparam int WB_DATA_WIDTH  = 64;
  localparam int WB_ADDR_WIDTH  = 5;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int REG_ZERO       = 0;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - long-latency result buffer with kill-by-rd and pending mask
module wb_result_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int REG_DEPTH  = 32,
  parameter int DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH-1:0] i_push_rd,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  input  logic                  i_kill_valid,
  input  logic [ADDR_WIDTH-1:0] i_kill_rd,
  output logic [ADDR_WIDTH-1:0] o_head_rd,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic                  o_head_live,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [REG_DEPTH-1:0]  o_pending_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_d   [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      kill_q, kill_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [REG_DEPTH-1:0]  mask_q, mask_d;

  // Next-state flags: kill matches, pop clears head, push fills tail (killed if rd matches the same-cycle write)
  always_comb begin
    valid_d = valid_q;
    kill_d  = kill_q;
    rd_d    = rd_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_kill_valid && valid_q[i] && (rd_q[i] == i_kill_rd)) kill_d[i] = 1'b1;
    end
    if (i_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      kill_d[rd_ptr_q]  = 1'b0;
    end
    if (i_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      kill_d[wr_ptr_q]  = i_kill_valid && (i_push_rd == i_kill_rd);
      rd_d[wr_ptr_q]    = i_push_rd;
    end
    mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_d[i] && !kill_d[i]) mask_d[rd_d[i]] = 1'b1;
    end
  end

  // Control state: pointers, occupancy, entry flags and the post-edge pending mask
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      kill_q   <= '0;
      mask_q   <= '0;
    end else begin
      valid_q <= valid_d;
      kill_q  <= kill_d;
      mask_q  <= mask_d;
      if (i_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (i_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Payload storage needs no reset; entries are qualified by their valid flags
  always_ff @(posedge i_clk) begin
    rd_q <= rd_d;
    if (i_push) data_q[wr_ptr_q] <= i_push_data;
  end

  assign o_head_rd      = rd_q[rd_ptr_q];
  assign o_head_data    = data_q[rd_ptr_q];
  assign o_head_live    = valid_q[rd_ptr_q] && !kill_q[rd_ptr_q];
  assign o_full         = (count_q == CNT_W'(DEPTH));
  assign o_empty        = (count_q == '0);
  assign o_pending_mask = mask_q;

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges pipeline and long-latency results onto register file write port 3
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int REG_DEPTH  = 32,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_wb_valid,
  input  logic [ADDR_WIDTH-1:0] i_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_lu_valid,
  input  logic [ADDR_WIDTH-1:0] i_lu_rd,
  input  logic [DATA_WIDTH-1:0] i_lu_data,
  output logic                  o_lu_ready,
  output logic                  o_write_en_3,
  output logic [ADDR_WIDTH-1:0] o_addr_3,
  output logic [DATA_WIDTH-1:0] o_write_data_3,
  output logic [REG_DEPTH-1:0]  o_pending_mask,
  output logic                  o_empty
);

  logic                  wb_hit, lu_push, fifo_pop;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_live, fifo_full, fifo_empty;
  logic [REG_DEPTH-1:0]  fifo_mask;

  // Writes to register zero are architecturally void, so they neither win the port nor kill entries
  assign wb_hit     = i_wb_valid && (i_wb_rd != ADDR_WIDTH'(REG_ZERO));
  assign o_lu_ready = i_rstn && !fifo_full;
  assign lu_push    = i_lu_valid && o_lu_ready && (i_lu_rd != ADDR_WIDTH'(REG_ZERO));
  assign fifo_pop   = i_rstn && !wb_hit && !fifo_empty;

  wb_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_DEPTH  (REG_DEPTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_push         (lu_push),
    .i_push_rd      (i_lu_rd),
    .i_push_data    (i_lu_data),
    .i_pop          (fifo_pop),
    .i_kill_valid   (wb_hit),
    .i_kill_rd      (i_wb_rd),
    .o_head_rd      (head_rd),
    .o_head_data    (head_data),
    .o_head_live    (head_live),
    .o_full         (fifo_full),
    .o_empty        (fifo_empty),
    .o_pending_mask (fifo_mask)
  );

  // Write port mux: pipeline first, then a live FIFO head; killed heads drain silently
  always_comb begin
    o_write_en_3   = 1'b0;
    o_addr_3       = '0;
    o_write_data_3 = '0;
    if (!i_rstn) begin
      o_write_en_3 = 1'b0;
    end else if (wb_hit) begin
      o_write_en_3   = 1'b1;
      o_addr_3       = i_wb_rd;
      o_write_data_3 = i_wb_data;
    end else if (!fifo_empty && head_live) begin
      o_write_en_3   = 1'b1;
      o_addr_3       = head_rd;
      o_write_data_3 = head_data;
    end
  end

  assign o_pending_mask = i_rstn ? fifo_mask : '0;
  assign o_empty        = !i_rstn || fifo_empty;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wb_valid, lu_valid;
  logic [4:0]  wb_rd, lu_rd;
  logic [63:0] wb_data, lu_data;
  logic        lu_ready, write_en, empty;
  logic [4:0]  addr;
  logic [63:0] write_data;
  logic [31:0] pending_mask;

  int tests_run = 0;
  int tests_failed = 0;
  wb_req_t exp_q[$];

  writeback_arbiter dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_wb_valid     (wb_valid),
    .i_wb_rd        (wb_rd),
    .i_wb_data      (wb_data),
    .i_lu_valid     (lu_valid),
    .i_lu_rd        (lu_rd),
    .i_lu_data      (lu_data),
    .o_lu_ready     (lu_ready),
    .o_write_en_3   (write_en),
    .o_addr_3       (addr),
    .o_write_data_3 (write_data),
    .o_pending_mask (pending_mask),
    .o_empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge clk);
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [63:0] data);
    wb_req_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Every register-file write seen mid-cycle is matched against the oldest expected write
  always @(negedge clk) begin
    if (rstn === 1'b1 && write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {59'd0, addr}, 64'hFFFF);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {59'd0, addr}, {59'd0, e.rd});
        chk("wr_data", write_data, e.data);
      end
    end
  end

  initial begin
    rstn = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 64'hDEAD;

    // Reset with a pending producer: nothing may be accepted
    step();
    wait_neg();
    chk("rst_ready", {63'd0, lu_ready}, 64'd0);
    chk("rst_we", {63'd0, write_en}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_mask", {32'd0, pending_mask}, 64'd0);
    step();
    rstn = 1'b1; lu_valid = 1'b0;
    wait_neg();
    chk("post_rst_ready", {63'd0, lu_ready}, 64'd1);
    chk("post_rst_empty", {63'd0, empty}, 64'd1);
    chk("post_rst_mask", {32'd0, pending_mask}, 64'd0);

    // Pipeline-only write, zero latency
    step();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hAA;
    expect_write(5'd5, 64'hAA);
    wait_neg();
    chk("wb_we", {63'd0, write_en}, 64'd1);
    step();
    wb_valid = 1'b0;

    // Long-latency push then drain on the next cycle
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 64'h1234;
    expect_write(5'd7, 64'h1234);
    wait_neg();
    chk("lu_ready_n", {63'd0, lu_ready}, 64'd1);
    step();
    lu_valid = 1'b0;
    wait_neg();
    chk("lu_mask7", {32'd0, pending_mask}, 64'h80);
    step();
    wait_neg();
    chk("lu_mask_clr", {32'd0, pending_mask}, 64'd0);
    chk("lu_empty", {63'd0, empty}, 64'd1);

    // Fill the FIFO behind continuous pipeline writes
    for (int i = 0; i < 4; i++) begin
      step();
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 64'h100 + 64'(i);
      expect_write(5'd1, 64'h100 + 64'(i));
      lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_data = 64'h500 + 64'(i);
      wait_neg();
      chk("fill_ready", {63'd0, lu_ready}, 64'd1);
    end
    step();
    lu_valid = 1'b0;
    wb_data = 64'h104;
    expect_write(5'd1, 64'h104);
    wait_neg();
    chk("full_ready", {63'd0, lu_ready}, 64'd0);
    chk("full_mask", {32'd0, pending_mask}, 64'h3C00);
    step();
    wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) expect_write(5'(10 + i), 64'h500 + 64'(i));
    for (int j = 0; j < 4; j++) begin
      wait_neg();
      chk("drain_ready", {63'd0, lu_ready}, (j == 0) ? 64'd0 : 64'd1);
      step();
    end
    wait_neg();
    chk("drain_empty", {63'd0, empty}, 64'd1);
    chk("drain_mask", {32'd0, pending_mask}, 64'd0);

    // Younger pipeline write kills a buffered result to the same rd
    step();
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 64'h11;
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 64'h77;
    expect_write(5'd2, 64'h77);
    step();
    lu_valid = 1'b0;
    wb_rd = 5'd9; wb_data = 64'h22;
    expect_write(5'd9, 64'h22);
    wait_neg();
    chk("kill_mask_pre", {32'd0, pending_mask}, 64'h200);
    step();
    wb_valid = 1'b0;
    wait_neg();
    chk("kill_mask_post", {32'd0, pending_mask}, 64'd0);
    chk("kill_no_we", {63'd0, write_en}, 64'd0);
    chk("kill_not_empty", {63'd0, empty}, 64'd0);
    step();
    wait_neg();
    chk("kill_empty", {63'd0, empty}, 64'd1);

    // Same-cycle push and pipeline write to rd 3: stored already killed
    step();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h33;
    expect_write(5'd3, 64'h33);
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 64'h44;
    step();
    wb_valid = 1'b0; lu_valid = 1'b0;
    wait_neg();
    chk("simkill_mask", {32'd0, pending_mask}, 64'd0);
    chk("simkill_no_we", {63'd0, write_en}, 64'd0);
    step();
    wait_neg();
    chk("simkill_empty", {63'd0, empty}, 64'd1);

    // Push to register zero is accepted and discarded; a wb write to r0 is ignored
    step();
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 64'h55;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'h66;
    wait_neg();
    chk("r0_ready", {63'd0, lu_ready}, 64'd1);
    chk("r0_no_we", {63'd0, write_en}, 64'd0);
    step();
    lu_valid = 1'b0; wb_valid = 1'b0;
    wait_neg();
    chk("r0_empty", {63'd0, empty}, 64'd1);
    chk("r0_mask", {32'd0, pending_mask}, 64'd0);

    step();
    step();
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
